// File: rtl/dispatch_stage_pkg.sv
// Shared definitions for the dispatch stage and the issue queue:
// entry field positions, RV32I opcodes and the packed entry layout.
package dispatch_stage_pkg;

    localparam int XLEN        = 32;
    localparam int ID_WIDTH    = 4;
    localparam int FIELD_WIDTH = 55;
    localparam int NUM_REGS    = 32;
    localparam int REG_W       = 5;

    // Entry field positions (issue queue decodes with the same constants)
    localparam int ID_MSB      = 54;
    localparam int ID_LSB      = 51;
    localparam int INSTR_MSB   = 50;
    localparam int INSTR_LSB   = 19;
    localparam int ALLOC_BIT   = 18;
    localparam int RS1_MSB     = 17;
    localparam int RS1_LSB     = 13;
    localparam int RS1_RDY_BIT = 12;
    localparam int RS2_MSB     = 11;
    localparam int RS2_LSB     = 7;
    localparam int RS2_RDY_BIT = 6;
    localparam int RD_MSB      = 5;
    localparam int RD_LSB      = 1;

    // RV32I major opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Issue-queue entry, MSB first; matches the field positions above
    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [XLEN-1:0]     instr;
        logic                alloc;
        logic [REG_W-1:0]    rs1;
        logic                rs1_rdy;
        logic [REG_W-1:0]    rs2;
        logic                rs2_rdy;
        logic [REG_W-1:0]    rd;
        logic                pad;
    } iq_entry_t;

    // Which register fields an instruction format actually uses
    typedef struct packed {
        logic rs1;
        logic rs2;
        logic rd;
    } reg_use_t;

    function automatic reg_use_t decode_use(input logic [6:0] opcode);
        reg_use_t u;
        u = '0;
        case (opcode)
            OP_R:                       u = '{rs1: 1'b1, rs2: 1'b1, rd: 1'b1};
            OP_IALU, OP_LOAD, OP_JALR:  u = '{rs1: 1'b1, rs2: 1'b0, rd: 1'b1};
            OP_STORE, OP_BRANCH:        u = '{rs1: 1'b1, rs2: 1'b1, rd: 1'b0};
            OP_LUI, OP_AUIPC, OP_JAL:   u = '{rs1: 1'b0, rs2: 1'b0, rd: 1'b1};
            default:                    u = '0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/dispatch_stage_busy_table.sv
// Register busy-bit scoreboard: one set port, one clear port (set wins),
// synchronous clear-all, two read ports with same-cycle writeback bypass.
module busy_table
    import dispatch_stage_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [REG_W-1:0] clr_idx,
    input  logic             clr_all,
    input  logic [REG_W-1:0] rd_idx_a,
    input  logic [REG_W-1:0] rd_idx_b,
    output logic             busy_a,
    output logic             busy_b
);

    logic [NUM_REGS-1:0] busy_q, busy_d;

    // Next busy vector: clear, then set (new producer supersedes), then flush
    always_comb begin
        busy_d = busy_q;
        if (clr_en)  busy_d[clr_idx] = 1'b0;
        if (set_en)  busy_d[set_idx] = 1'b1;
        if (clr_all) busy_d = '0;
        busy_d[0] = 1'b0;
    end

    // Busy state register
    always_ff @(posedge clk) begin
        if (!resetn) busy_q <= '0;
        else         busy_q <= busy_d;
    end

    // Read ports: a writeback landing this cycle already counts as not busy
    always_comb begin
        busy_a = busy_q[rd_idx_a] & ~(clr_en & (clr_idx == rd_idx_a));
        busy_b = busy_q[rd_idx_b] & ~(clr_en & (clr_idx == rd_idx_b));
    end

endmodule

// File: rtl/dispatch_stage.sv
// Dispatch stage: decodes register usage, checks the scoreboard, builds the
// issue-queue entry and holds it in a registered valid/ready output slot.
module dispatch_stage
    import dispatch_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FIELD_WIDTH-1:0] out_entry,
    input  logic                   wb_valid,
    input  logic [REG_W-1:0]       wb_rd,
    input  logic                   flush
);

    reg_use_t            use_w;
    logic [REG_W-1:0]    rs1_idx, rs2_idx, rd_idx;
    logic                rs1_busy, rs2_busy;
    logic                accept, xfer;

    logic                out_valid_q, out_valid_d;
    iq_entry_t           entry_q, entry_d;
    logic [ID_WIDTH-1:0] id_cnt_q, id_cnt_d;

    // Field extraction; unused fields collapse to x0, which is never busy
    always_comb begin
        use_w   = decode_use(instr[6:0]);
        rs1_idx = use_w.rs1 ? instr[19:15] : '0;
        rs2_idx = use_w.rs2 ? instr[24:20] : '0;
        rd_idx  = use_w.rd  ? instr[11:7]  : '0;
    end

    busy_table u_busy (
        .clk      (clk),
        .resetn   (resetn),
        .set_en   (accept & (rd_idx != '0)),
        .set_idx  (rd_idx),
        .clr_en   (wb_valid),
        .clr_idx  (wb_rd),
        .clr_all  (flush),
        .rd_idx_a (rs1_idx),
        .rd_idx_b (rs2_idx),
        .busy_a   (rs1_busy),
        .busy_b   (rs2_busy)
    );

    // Handshake: slot frees when empty or being drained this cycle
    always_comb begin
        in_ready = ~out_valid_q | out_ready;
        accept   = in_valid & in_ready & ~flush;
        xfer     = out_valid_q & out_ready;
    end

    // Output slot next state: flush, load new entry, drain, or wake up sources
    always_comb begin
        out_valid_d = out_valid_q;
        entry_d     = entry_q;
        id_cnt_d    = id_cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d     = 1'b1;
            entry_d.id      = id_cnt_q;
            entry_d.instr   = instr;
            entry_d.alloc   = 1'b1;
            entry_d.rs1     = rs1_idx;
            entry_d.rs1_rdy = ~rs1_busy;
            entry_d.rs2     = rs2_idx;
            entry_d.rs2_rdy = ~rs2_busy;
            entry_d.rd      = rd_idx;
            entry_d.pad     = 1'b0;
            id_cnt_d        = id_cnt_q + 4'd1;
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end else if (out_valid_q && wb_valid && (wb_rd != '0)) begin
            if (entry_q.rs1 == wb_rd) entry_d.rs1_rdy = 1'b1;
            if (entry_q.rs2 == wb_rd) entry_d.rs2_rdy = 1'b1;
        end
    end

    // Output slot and tag counter registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            entry_q     <= '0;
            id_cnt_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            entry_q     <= entry_d;
            id_cnt_q    <= id_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_entry = entry_q;

endmodule

// File: tb/tb_dispatch_stage.sv
// Self-checking bench for dispatch_stage: directed scenarios plus random
// traffic, all compared against a behavioural scoreboard model.
module tb_dispatch_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [54:0] out_entry;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;

    int tests_run = 0;
    int fails     = 0;

    // Reference model state
    logic        m_valid;
    logic [54:0] m_ent;
    logic [31:0] m_busy;
    logic [3:0]  m_id;

    dispatch_stage dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_entry (out_entry),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .flush     (flush)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input int rd, input int rs1, input int rs2);
        logic [31:0] v;
        v = 32'h33;
        v[11:7] = rd[4:0]; v[19:15] = rs1[4:0]; v[24:20] = rs2[4:0];
        return v;
    endfunction

    function automatic logic [31:0] enc_i(input int rd, input int rs1);
        logic [31:0] v;
        v = 32'h13;
        v[11:7] = rd[4:0]; v[19:15] = rs1[4:0];
        return v;
    endfunction

    // Model entry from the format table and the model's busy bits
    function automatic logic [54:0] m_build(input logic [31:0] ins);
        logic [2:0] u;
        logic [4:0] r1, r2, rd;
        logic       k1, k2;
        case (ins[6:0])
            7'b0110011:                         u = 3'b111;
            7'b0010011, 7'b0000011, 7'b1100111: u = 3'b101;
            7'b0100011, 7'b1100011:             u = 3'b110;
            7'b0110111, 7'b0010111, 7'b1101111: u = 3'b001;
            default:                            u = 3'b000;
        endcase
        r1 = u[2] ? ins[19:15] : 5'd0;
        r2 = u[1] ? ins[24:20] : 5'd0;
        rd = u[0] ? ins[11:7]  : 5'd0;
        k1 = (r1 == 0) || !m_busy[r1] || (wb_valid && wb_rd == r1);
        k2 = (r2 == 0) || !m_busy[r2] || (wb_valid && wb_rd == r2);
        return {m_id, ins, 1'b1, r1, k1, r2, k2, rd, 1'b0};
    endfunction

    task automatic drive(input logic iv, input logic [31:0] ins, input logic ordy,
                         input logic wv, input logic [4:0] wr, input logic fl);
        in_valid = iv; instr = ins; out_ready = ordy;
        wb_valid = wv; wb_rd = wr; flush = fl;
    endtask

    // Advance model with the currently driven inputs, then clock the DUT
    task automatic tick();
        logic acc, xf;
        acc = in_valid && (!m_valid || out_ready) && !flush;
        xf  = m_valid && out_ready;
        if (!resetn) begin
            m_valid = 0; m_ent = '0; m_busy = '0; m_id = '0;
        end else if (flush) begin
            m_valid = 0; m_busy = '0;
        end else begin
            if (acc) begin
                m_ent = m_build(instr);
                m_valid = 1;
                m_id = m_id + 4'd1;
            end else if (xf) begin
                m_valid = 0;
            end else if (m_valid && wb_valid && wb_rd != 0) begin
                if (m_ent[17:13] == wb_rd) m_ent[12] = 1'b1;
                if (m_ent[11:7]  == wb_rd) m_ent[6]  = 1'b1;
            end
            if (wb_valid) m_busy[wb_rd] = 1'b0;
            if (acc && m_ent[5:1] != 0) m_busy[m_ent[5:1]] = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        resetn = 0;
        drive(0, 32'h0, 0, 0, 5'd0, 0);
        tick(); tick();
        resetn = 1;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (out_valid !== 1'b0 || out_entry !== 55'd0) begin
            fails++; $display("FAIL reset_state: got valid=%b entry=%h want 0/0", out_valid, out_entry);
        end
        #1; tests_run++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [54:0] exp;
        do_reset();
        drive(1, 32'h002081B3, 1, 0, 5'd0, 0);
        tick();
        exp = {4'd0, 32'h002081B3, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0};
        tests_run++;
        if (out_valid !== 1'b1 || out_entry !== exp) begin
            fails++; $display("FAIL basic_add: got v=%b %h want v=1 %h", out_valid, out_entry, exp);
        end
        // consumer of x3 sees it busy
        drive(1, enc_r(4, 3, 0), 1, 0, 5'd0, 0);
        tick();
        tests_run++;
        if (out_entry[12] !== 1'b0 || out_entry[6] !== 1'b1 || out_entry !== m_ent) begin
            fails++; $display("FAIL basic_busy3: got %h want %h", out_entry, m_ent);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1, 32'h00100293, 1, 0, 5'd0, 0); tick();
        drive(1, 32'h00528333, 1, 0, 5'd0, 0); tick();
        tests_run++;
        if (out_entry[54:51] !== 4'd1 || out_entry[12] !== 1'b0 || out_entry[6] !== 1'b0
            || out_entry !== m_ent) begin
            fails++; $display("FAIL b2b_dep: got %h want id=1 rdy=0/0 (%h)", out_entry, m_ent);
        end
        drive(0, 32'h0, 0, 1, 5'd5, 0); tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_entry[12] !== 1'b1 || out_entry[6] !== 1'b1
            || out_entry !== m_ent) begin
            fails++; $display("FAIL b2b_wakeup: got v=%b %h want v=1 %h", out_valid, out_entry, m_ent);
        end
    endtask

    task automatic test_stall();
        logic [54:0] held;
        do_reset();
        drive(1, enc_i(1, 0), 1, 0, 5'd0, 0); tick();
        held = {4'd0, enc_i(1, 0), 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(1, enc_i(2, 0), 0, 0, 5'd0, 0);
            #1; tests_run++;
            if (in_ready !== 1'b0) begin
                fails++; $display("FAIL stall_in_ready: cycle %0d got %b want 0", i, in_ready);
            end
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || out_entry !== held) begin
                fails++; $display("FAIL stall_hold: cycle %0d got %h want %h", i, out_entry, held);
            end
        end
        drive(1, enc_i(2, 0), 1, 0, 5'd0, 0);
        #1; tests_run++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL stall_release: got %b want 1", in_ready);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_entry[54:51] !== 4'd1 || out_entry[50:19] !== enc_i(2, 0)) begin
            fails++; $display("FAIL stall_xfer_accept: got %h want id=1 instr=%h", out_entry, enc_i(2, 0));
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1, enc_i(0, 0), 1, 0, 5'd0, 0); tick();
            tests_run++;
            if (out_entry[54:51] !== 4'(i % 16)) begin
                fails++; $display("FAIL id_wrap: accept %0d got id %0d want %0d", i, out_entry[54:51], i % 16);
            end
        end
    endtask

    task automatic test_set_bypass();
        do_reset();
        drive(1, enc_i(7, 0), 1, 1, 5'd7, 0); tick();
        drive(1, enc_r(9, 7, 0), 1, 0, 5'd0, 0); tick();
        tests_run++;
        if (out_entry[12] !== 1'b0) begin
            fails++; $display("FAIL set_wins: rs1_rdy got %b want 0", out_entry[12]);
        end
        drive(1, enc_i(8, 0), 1, 0, 5'd0, 0); tick();
        drive(1, enc_i(10, 8), 1, 1, 5'd8, 0); tick();
        tests_run++;
        if (out_entry[12] !== 1'b1 || out_entry !== m_ent) begin
            fails++; $display("FAIL wb_bypass: got %h want %h", out_entry, m_ent);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, enc_i(5, 0), 1, 0, 5'd0, 0); tick();
        drive(1, enc_i(6, 0), 0, 0, 5'd0, 1); tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL flush_valid: got %b want 0", out_valid);
        end
        drive(1, enc_r(6, 5, 5), 1, 0, 5'd0, 0); tick();
        tests_run++;
        if (out_entry[54:51] !== 4'd1 || out_entry[12] !== 1'b1 || out_entry[6] !== 1'b1) begin
            fails++; $display("FAIL flush_busy_id: got %h want id=1 rdy=1/1", out_entry);
        end
        drive(1, 32'h00112023, 1, 0, 5'd0, 0); tick();
        tests_run++;
        if (out_entry[5:1] !== 5'd0 || out_entry[17:13] !== 5'd2 || out_entry[11:7] !== 5'd1) begin
            fails++; $display("FAIL store_fields: got %h want rs1=2 rs2=1 rd=0", out_entry);
        end
        // rd field of the store must not have marked x0..x31 busy: read x2 back
        drive(1, enc_r(3, 2, 0), 1, 0, 5'd0, 0); tick();
        tests_run++;
        if (out_entry !== m_ent || out_entry[12] !== 1'b1) begin
            fails++; $display("FAIL store_no_busy: got %h want %h", out_entry, m_ent);
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops [11];
        logic [31:0] ins;
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h7f, 7'h0b};
        do_reset();
        for (int i = 0; i < 600; i++) begin
            ins = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 10)];
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            resetn = ($urandom_range(0, 149) != 0);
            drive($urandom_range(0, 3) != 0, ins, $urandom_range(0, 2) != 0,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 39) == 0);
            #1; tests_run++;
            if (in_ready !== (!m_valid || out_ready)) begin
                fails++; $display("FAIL rand_in_ready: cycle %0d got %b want %b", i, in_ready, !m_valid || out_ready);
            end
            tick();
            tests_run++;
            if (out_valid !== m_valid || (m_valid && out_entry !== m_ent)) begin
                fails++; $display("FAIL rand_out: cycle %0d got v=%b %h want v=%b %h",
                                  i, out_valid, out_entry, m_valid, m_ent);
            end
        end
        resetn = 1;
    endtask

    initial begin
        resetn = 0;
        drive(0, 32'h0, 0, 0, 5'd0, 0);
        m_valid = 0; m_ent = '0; m_busy = '0; m_id = '0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_wrap();
        test_set_bypass();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/dispatch_stage.md
# dispatch_stage

Front-end stage directly upstream of the issue queue. Accepts one decoded-in-place RV32I instruction per cycle and looks up source-register readiness in a busy-bit scoreboard. Builds the 55-bit issue-queue entry and presents it through a registered valid/ready handshake. Writeback broadcasts clear busy bits and wake up the entry held in the output register.

## Interface
- XLEN, 32, instruction width
- ID_WIDTH, 4, instruction tag width (wraps)
- FIELD_WIDTH, 55, issue-queue entry width
- NUM_REGS, 32, architectural registers (5-bit indices)

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- in_valid  in  1  fetch offers instr
- in_ready  out  1  stage can accept this cycle
- instr  in  XLEN  raw instruction
- out_valid  out  1  out_entry holds a valid entry
- out_ready  in  1  issue queue can enqueue (driven as !full)
- out_entry  out  FIELD_WIDTH  entry {id[54:51], instr[50:19], alloc[18]=1, rs1[17:13], rs1_rdy[12], rs2[11:7], rs2_rdy[6], rd[5:1], 1'b0}
- wb_valid  in  1  a result is written back this cycle
- wb_rd  in  5  destination of that writeback
- flush  in  1  discard held entry, clear scoreboard

## Operation
- Format is decoded from opcode[6:0]:
  - R (0110011): uses rs1, rs2, rd
  - I-ALU (0010011), LOAD (0000011), JALR (1100111): uses rs1, rd
  - STORE (0100011), BRANCH (1100011): uses rs1, rs2; no rd
  - LUI (0110111), AUIPC (0010111), JAL (1101111): uses rd only
  - Any other opcode: no sources, no rd
- Field handling:
  - Unused source fields are emitted as 0 with ready=1.
  - An unused rd is emitted as 0.
- Source ready = !used | (rs==0) | !busy[rs] | (wb_valid & wb_rd==rs & rs!=0). The last term is a same-cycle bypass.
- Accept condition: in_valid & in_ready & !flush. On accept:
  - The entry is latched into the output register.
  - id_cnt is stamped into the entry, then incremented mod 2^ID_WIDTH.
  - If rd is used and nonzero, busy[rd] is set.
- Busy table:
  - busy[0] is hard-wired 0.
  - wb_valid clears busy[wb_rd].
  - Simultaneous set and clear of the same register: set wins, because the new producer supersedes.
- Wakeup of the held entry: while out_valid and not being consumed, wb_valid & wb_rd==rs1/rs2 (nonzero) sets the matching ready bit in out_entry.
- Flush:
  - out_valid is cleared and all busy bits are cleared.
  - id_cnt is retained.
  - An instruction offered in the flush cycle is not accepted.

## Timing
- in_ready = !out_valid | out_ready. This is combinational, and there are no other combinational in→out paths.
- Latency is 1 cycle: an instruction accepted at edge N is visible on out_entry/out_valid after edge N.
- Handshake:
  - Transfer occurs when out_valid & out_ready.
  - Accept and transfer in the same cycle sustain 1 instr/cycle.
  - out_entry is stable while out_valid & !out_ready, except for wakeup ready-bit sets.
- Reset values (resetn low at an edge):
  - out_valid=0, out_entry=0, busy=0, id_cnt=0.
  - in_ready=1 immediately after reset.
- Reset mid-handshake drops the held entry with no transfer.
- Back-to-back dependence (producer rd=x5 then consumer rs1=x5): the consumer sees busy[5]=1, so rs1_rdy=0.

## Structure
- Shared package holds:
  - Entry field position localparams (ID_MSB/LSB, INSTR, ALLOC, RS1, RS1_RDY, RS2, RS2_RDY, RD). The issue queue uses the same constants.
  - Opcode constants and a packed struct for the entry.
- Sub-module busy_table: NUM_REGS-bit register with one set port, one clear port (set priority), a synchronous clear-all, and two combinational read ports including the wb bypass.

## Test plan
- Reset, then instr 0x00208033 (add x0? use add x3,x1,x2 = 0x002081B3), in_valid=1, out_ready=1 -> next cycle out_valid=1, id=0, rs1=1, rs2=2, rd=3, both rdy=1, alloc=1, busy[3]=1.
- addi x5,x0,1 then add x6,x5,x5 back-to-back -> second entry id=1, rs1_rdy=rs2_rdy=0; then wb_valid, wb_rd=5 while held with out_ready=0 -> both ready bits set next cycle.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_entry unchanged, id_cnt unchanged; out_ready=1 -> transfer plus new accept in the same cycle.
- 17 accepted instructions -> ids 0..15 then 0 (wrap).
- Same cycle: dispatch rd=7 and wb_rd=7 -> busy[7]=1 afterwards. Dispatch rs1=8 with wb_rd=8 -> rs1_rdy=1 (bypass).
- flush with held entry and busy bits set -> out_valid=0, busy all 0, id_cnt kept; sw x1,0(x2) -> rd field 0, no busy set.
